pll_reset_cen_seq: RTL and testbench
====================================

Name: pll_reset_cen_seq

Overview:
- Sits directly downstream of the system PLL, in the clk_sys (48 MHz) domain.
- Takes the PLL's asynchronous locked flag and sequences a clean, synchronous core reset. Reset is released only after lock has been stable and a hold interval has elapsed.
- Generates the clock enables the arcade core derives from clk_sys: one integer divider and one fractional-rate enable for the sound chip.
- Reasserts core reset whenever lock is lost or the user requests a reset.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the pll_locked synchronizer (legal range 2..4).
- STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before the hold phase starts.
- HOLD_CYCLES, 256, cycles core_reset stays high after stability is reached.
- DIV_N, 8, period of cen_div in clk_sys cycles (legal range >= 2). With the default, cen_div = 6 MHz.
- FRAC_NUM, 179, fractional accumulator increment.
- FRAC_DEN, 4800, fractional accumulator modulus. Requires FRAC_NUM < FRAC_DEN. With the defaults, cen_frac averages 1.79 MHz.

Ports:
- clk_sys  in  1  system clock, 48 MHz.
- reset  in  1  asynchronous, active-high; forces all state to reset values.
- pll_locked  in  1  PLL lock flag, asynchronous to clk_sys.
- user_reset  in  1  synchronous, active-high OSD/button reset request.
- core_reset  out  1  synchronous active-high reset for the core; reset value 1.
- cen_div  out  1  one-cycle pulse every DIV_N cycles; reset value 0.
- cen_frac  out  1  fractional-rate one-cycle pulse; reset value 0.
- seq_state  out  2  current FSM state encoding; reset value 0.
- lock_loss_cnt  out  8  saturating count of lock losses seen in RUN; reset value 0.

Behaviour:
- Sync: pll_locked passes through SYNC_STAGES flops to produce lk_s. All flops reset to 0.
- FSM states and encodings: WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3.
- WAIT_LOCK: counter = 0. Go to STABLE when lk_s = 1.
- STABLE: counter increments each cycle while lk_s = 1. Return to WAIT_LOCK if lk_s = 0. Go to HOLD when counter == STABLE_CYCLES-1; counter clears on this transition.
- HOLD: counter increments each cycle. Go to WAIT_LOCK if lk_s = 0. Go to RUN when counter == HOLD_CYCLES-1.
- RUN: if lk_s = 0, go to WAIT_LOCK and increment lock_loss_cnt, saturating at 255. If user_reset = 1, go to HOLD with counter cleared; stability is not re-checked.
- Simultaneous lk_s = 0 and user_reset = 1 in RUN: lock loss wins. Next state is WAIT_LOCK and the counter increments.
- core_reset: registered, = (next_state != RUN). It falls exactly one cycle after the FSM enters RUN's predecessor condition. It rises on the cycle after the lock-loss or user_reset sample.
- Total release latency from lk_s first high with uninterrupted lock: STABLE_CYCLES + HOLD_CYCLES + 1 cycles to core_reset = 0.
- Divider counter runs only while state == RUN and is held at 0 otherwise. cen_div = 1 when the counter == DIV_N-1, then the counter wraps to 0. The first cen_div occurs DIV_N cycles after core_reset falls.
- Fractional accumulator acc: width ceil(log2(FRAC_DEN+FRAC_NUM)); held at 0 outside RUN.
  - In RUN, each cycle: if acc + FRAC_NUM >= FRAC_DEN, then acc <= acc + FRAC_NUM - FRAC_DEN and cen_frac <= 1.
  - Otherwise acc <= acc + FRAC_NUM and cen_frac <= 0.
  - Exactly FRAC_NUM pulses per FRAC_DEN cycles. No two consecutive pulses when FRAC_NUM*2 <= FRAC_DEN.
- Both enables are 0 whenever core_reset = 1.
- Asynchronous reset mid-operation: all outputs return to reset values immediately. lock_loss_cnt clears; only the asynchronous reset clears it.

Optional Feature:
- Macro: PLL_SEQ_FRAC_CEN_EN.
- Defined: the fractional accumulator and cen_frac are implemented as above.
- Undefined: the accumulator is not instantiated and cen_frac is tied to 0. The FRAC_NUM and FRAC_DEN parameters are accepted but unused. All other behaviour is identical.

Test Plan:
- Cold start: reset high for 5 cycles, then pll_locked = 1 constant (defaults) -> core_reset = 1 until 1024+256+SYNC_STAGES+1 cycles after pll_locked rises, then 0. seq_state steps 0, 1, 2, 3.
- Lock glitch in STABLE: pll_locked low for 3 cycles at cycle 500 of STABLE -> FSM returns to WAIT_LOCK, the counter restarts, and the full 1024+256 count is required again. lock_loss_cnt stays 0.
- Lock loss in RUN, repeated 300 times -> core_reset rises 1 cycle after lk_s falls each time, cen_div and cen_frac stop, and lock_loss_cnt saturates at 255.
- user_reset 1-cycle pulse in RUN -> seq_state = 2 and core_reset = 1 for exactly 256 cycles, then RUN again; the STABLE phase is skipped.
- Enable rates over 48000 RUN cycles -> exactly 6000 cen_div pulses spaced 8 apart, and (with PLL_SEQ_FRAC_CEN_EN) exactly 1790 cen_frac pulses. With the macro undefined, cen_frac is always 0.
- user_reset and lock loss in the same RUN cycle -> seq_state = 0 next cycle and lock_loss_cnt increments by 1.

Source files
------------

// File: rtl/pll_reset_cen_seq.sv
// ============================================================================
// Module   : pll_reset_cen_seq
// Purpose  : PLL-lock driven core reset sequencer with integer and fractional
//            clock-enable generation in the clk_sys domain.
// Option   : PLL_SEQ_FRAC_CEN_EN enables the fractional accumulator/cen_frac.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_reset_cen_seq #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 256,
    parameter int DIV_N         = 8,
    parameter int FRAC_NUM      = 179,
    parameter int FRAC_DEN      = 4800
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       user_reset,
    output logic       core_reset,
    output logic       cen_div,
    output logic       cen_frac,
    output logic [1:0] seq_state,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    localparam int c_cnt_max = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max) + 1;
    localparam int c_div_w   = $clog2(DIV_N);
    localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last   = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_div_w-1:0] c_div_last    = c_div_w'(DIV_N - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lk;
    state_t                 r_state;
    state_t                 w_next;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     w_cnt_next;
    logic                   w_loss;
    logic                   w_run;
    logic                   r_core_reset;
    logic [7:0]             r_lock_loss_cnt;
    logic [c_div_w-1:0]     r_div_cnt;
    logic                   r_cen_div;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign w_lk = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_loss     = 1'b0;
        case (r_state)
            ST_WAIT_LOCK: begin
                w_cnt_next = '0;
                if (w_lk) w_next = ST_STABLE;
            end
            ST_STABLE: begin
                if (!w_lk) begin
                    w_next     = ST_WAIT_LOCK;
                    w_cnt_next = '0;
                end else if (r_cnt == c_stable_last) begin
                    w_next     = ST_HOLD;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_w'(1);
                end
            end
            ST_HOLD: begin
                if (!w_lk) begin
                    w_next     = ST_WAIT_LOCK;
                    w_cnt_next = '0;
                end else if (r_cnt == c_hold_last) begin
                    w_next     = ST_RUN;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_w'(1);
                end
            end
            ST_RUN: begin
                w_cnt_next = '0;
                // Lock loss outranks a coincident user reset request.
                if (!w_lk) begin
                    w_next = ST_WAIT_LOCK;
                    w_loss = 1'b1;
                end else if (user_reset) begin
                    w_next = ST_HOLD;
                end
            end
            default: begin
                w_next     = ST_WAIT_LOCK;
                w_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state         <= ST_WAIT_LOCK;
            r_cnt           <= '0;
            r_core_reset    <= 1'b1;
            r_lock_loss_cnt <= '0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_next;
            r_core_reset <= (w_next != ST_RUN);
            if (w_loss && (r_lock_loss_cnt != 8'hFF)) begin
                r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
            end
        end
    end

    // Enables advance only when RUN persists, so they never pulse with core_reset high.
    assign w_run = (r_state == ST_RUN) && (w_next == ST_RUN);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_cen_div <= 1'b0;
        end else if (w_run) begin
            r_cen_div <= (r_div_cnt == c_div_last);
            r_div_cnt <= (r_div_cnt == c_div_last) ? '0 : r_div_cnt + c_div_w'(1);
        end else begin
            r_div_cnt <= '0;
            r_cen_div <= 1'b0;
        end
    end

`ifdef PLL_SEQ_FRAC_CEN_EN
    localparam int c_acc_w = $clog2(FRAC_DEN + FRAC_NUM);

    logic [c_acc_w-1:0] r_acc;
    logic [c_acc_w-1:0] w_acc_sum;
    logic               r_cen_frac;

    assign w_acc_sum = r_acc + c_acc_w'(FRAC_NUM);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_acc      <= '0;
            r_cen_frac <= 1'b0;
        end else if (w_run) begin
            if (w_acc_sum >= c_acc_w'(FRAC_DEN)) begin
                r_acc      <= w_acc_sum - c_acc_w'(FRAC_DEN);
                r_cen_frac <= 1'b1;
            end else begin
                r_acc      <= w_acc_sum;
                r_cen_frac <= 1'b0;
            end
        end else begin
            r_acc      <= '0;
            r_cen_frac <= 1'b0;
        end
    end

    assign cen_frac = r_cen_frac;
`else
    logic w_unused_frac;
    assign w_unused_frac = ^{FRAC_NUM, FRAC_DEN};
    assign cen_frac      = 1'b0;
`endif

    assign core_reset    = r_core_reset;
    assign cen_div       = r_cen_div;
    assign seq_state     = r_state;
    assign lock_loss_cnt = r_lock_loss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_cen_seq.sv
// ============================================================================
// Module   : tb_pll_reset_cen_seq
// Purpose  : Self-checking bench; lock-history reference model plus directed
//            and randomized stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_reset_cen_seq;

    localparam int SYNC = 2;
    localparam int S    = 40;
    localparam int H    = 24;
    localparam int DIV  = 8;
    localparam int NUM  = 179;
    localparam int DEN  = 4800;

    logic       clk_sys    = 1'b0;
    logic       reset      = 1'b0;
    logic       pll_locked = 1'b0;
    logic       user_reset = 1'b0;
    logic       core_reset;
    logic       cen_div;
    logic       cen_frac;
    logic [1:0] seq_state;
    logic [7:0] lock_loss_cnt;

    int n_chk  = 0;
    int n_err  = 0;
    bit cmp_en = 1'b0;

    // Model: m_c counts consecutive locked samples; the phase follows from it.
    int m_c   = 0;
    int m_llc = 0;
    int m_k   = 0;
    bit m_div = 1'b0;
    bit m_frac = 1'b0;
    bit m_sync [SYNC];

    pll_reset_cen_seq #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (S),
        .HOLD_CYCLES   (H),
        .DIV_N         (DIV),
        .FRAC_NUM      (NUM),
        .FRAC_DEN      (DEN)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .pll_locked    (pll_locked),
        .user_reset    (user_reset),
        .core_reset    (core_reset),
        .cen_div       (cen_div),
        .cen_frac      (cen_frac),
        .seq_state     (seq_state),
        .lock_loss_cnt (lock_loss_cnt)
    );

    initial forever #5 clk_sys = ~clk_sys;

    function automatic int phase(input int c);
        if (c == 0) return 0;
        if (c <= S) return 1;
        if (c <= S + H) return 2;
        return 3;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit lk;
        int prev;
        int now;
        if (reset) begin
            m_c = 0; m_llc = 0; m_k = 0; m_div = 1'b0; m_frac = 1'b0;
            for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
            return;
        end
        lk = m_sync[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = pll_locked;
        prev = phase(m_c);
        if (!lk) begin
            if (prev == 3 && m_llc < 255) m_llc++;
            m_c = 0;
        end else if (prev == 3 && user_reset) begin
            m_c = S + 1;
        end else if (m_c < S + H + 1) begin
            m_c++;
        end
        now = phase(m_c);
        m_k   = (prev == 3 && now == 3) ? m_k + 1 : 0;
        m_div = (m_k > 0) && (m_k % DIV == 0);
`ifdef PLL_SEQ_FRAC_CEN_EN
        m_frac = (m_k > 0) && ((longint'(m_k) * NUM) / DEN != (longint'(m_k - 1) * NUM) / DEN);
`else
        m_frac = 1'b0;
`endif
    endtask

    initial begin
        for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
        forever begin
            @(posedge clk_sys or posedge reset);
            model_step();
        end
    end

    initial forever begin
        @(negedge clk_sys);
        if (cmp_en) begin
            chk("seq_state", int'(seq_state), phase(m_c));
            chk("core_reset", int'(core_reset), (phase(m_c) != 3) ? 1 : 0);
            chk("cen_div", int'(cen_div), int'(m_div));
            chk("cen_frac", int'(cen_frac), int'(m_frac));
            chk("lock_loss_cnt", int'(lock_loss_cnt), m_llc);
        end
    end

    task automatic do_reset();
        @(negedge clk_sys);
        reset = 1'b1;
        repeat (5) @(negedge clk_sys);
        reset = 1'b0;
    endtask

    // Counts clock edges from the current negedge until core_reset is seen low.
    task automatic wait_release(output int n);
        n = 0;
        while (n < 2000) begin
            @(posedge clk_sys);
            n++;
            @(negedge clk_sys);
            if (!core_reset) return;
        end
        n = -1;
    endtask

    int lat;
    int hold_n;
    int nd, nf, last_d, bad_gap, consec;
    bit prev_f;
    int llc_before;

    initial begin
        do_reset();
        cmp_en = 1'b1;
        chk("rst_core_reset", int'(core_reset), 1);
        chk("rst_seq_state", int'(seq_state), 0);
        chk("rst_cen_div", int'(cen_div), 0);
        chk("rst_lock_loss", int'(lock_loss_cnt), 0);

        // Cold start: release 67 edges after lock (S + H + SYNC + 1).
        pll_locked = 1'b1;
        lat = 0;
        while (lat < 2000) begin
            @(posedge clk_sys);
            lat++;
            @(negedge clk_sys);
            if (lat == 2)  chk("cold_seq_n2", int'(seq_state), 0);
            if (lat == 3)  chk("cold_seq_n3", int'(seq_state), 1);
            if (lat == 43) chk("cold_seq_n43", int'(seq_state), 2);
            if (!core_reset) break;
        end
        chk("cold_latency", lat, 67);
        chk("cold_seq_run", int'(seq_state), 3);

        // User reset pulse: HOLD only, for H cycles.
        repeat (10) @(negedge clk_sys);
        user_reset = 1'b1;
        @(negedge clk_sys);
        user_reset = 1'b0;
        hold_n = 0;
        while (hold_n < 500 && seq_state == 2'd2 && core_reset) begin
            hold_n++;
            @(negedge clk_sys);
        end
        chk("user_hold_len", hold_n, 24);
        chk("user_back_run", int'(seq_state), 3);

        // Lock loss and user reset land on the same sampled edge.
        repeat (5) @(negedge clk_sys);
        llc_before = int'(lock_loss_cnt);
        pll_locked = 1'b0;
        repeat (SYNC) @(negedge clk_sys);
        user_reset = 1'b1;
        @(negedge clk_sys);
        user_reset = 1'b0;
        chk("both_seq", int'(seq_state), 0);
        chk("both_llc", int'(lock_loss_cnt), llc_before + 1);

        // Lock glitch during STABLE forces a full restart.
        do_reset();
        pll_locked = 1'b1;
        repeat (22) @(negedge clk_sys);
        chk("glitch_in_stable", int'(seq_state), 1);
        pll_locked = 1'b0;
        repeat (3) @(negedge clk_sys);
        pll_locked = 1'b1;
        wait_release(lat);
        chk("glitch_latency", lat, 67);
        chk("glitch_llc", int'(lock_loss_cnt), 0);

        // Repeated lock loss in RUN saturates the loss counter.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_sys);
            pll_locked = 1'b0;
            repeat (4) @(negedge clk_sys);
            pll_locked = 1'b1;
            wait_release(lat);
            chk("relock_latency", lat, 67);
        end
        chk("llc_saturated", int'(lock_loss_cnt), 255);

        // Enable rates across 48000 RUN cycles.
        nd = 0; nf = 0; last_d = 0; bad_gap = 0; consec = 0; prev_f = 1'b0;
        for (int i = 1; i <= 48000; i++) begin
            @(negedge clk_sys);
            if (cen_div) begin
                nd++;
                if ((last_d == 0 && i != DIV) || (last_d != 0 && i - last_d != DIV)) bad_gap++;
                last_d = i;
            end
            if (cen_frac) begin
                nf++;
                if (prev_f) consec++;
            end
            prev_f = cen_frac;
        end
        chk("div_pulses", nd, 6000);
        chk("div_spacing", bad_gap, 0);
`ifdef PLL_SEQ_FRAC_CEN_EN
        chk("frac_pulses", nf, 1790);
`else
        chk("frac_pulses", nf, 0);
`endif
        chk("frac_consecutive", consec, 0);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk_sys);
        #2 reset = 1'b1;
        #1;
        chk("async_core_reset", int'(core_reset), 1);
        chk("async_seq_state", int'(seq_state), 0);
        chk("async_cen_div", int'(cen_div), 0);
        chk("async_llc", int'(lock_loss_cnt), 0);
        @(negedge clk_sys);
        reset = 1'b0;
        wait_release(lat);
        chk("post_async_latency", lat, 67);

        // Randomized lock and user-reset activity against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_sys);
            if ($urandom_range(149, 0) == 0) pll_locked = ~pll_locked;
            user_reset = ($urandom_range(59, 0) == 0);
        end
        @(negedge clk_sys);
        user_reset = 1'b0;
        @(negedge clk_sys);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
